// File: rtl/ccr_unit.sv
// ccr_unit: execute-stage condition-code register with an optional shadow stack.
// Flags are held internally as {V,Z,N,C} and fed back to the ALU flag inputs.
// Build option: define CCR_SHADOW_EN to build the interrupt shadow stack
// (push/pop, shadowDepth, ccrError). Without it the block is a plain
// stall-able 4-bit flag register and push/pop are ignored.
// DEPTH is the shadow stack depth; the legal range is 1..8, which keeps the
// pointer inside the 4-bit shadowDepth output.
module ccr_unit #(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       flagWrite,
  input  logic       zeroFlagIn,
  input  logic       carryFlagIn,
  input  logic       overFlowFlagIn,
  input  logic       negativeFlagIn,
  input  logic       push,
  input  logic       pop,
  output logic       zeroFlag,
  output logic       carryFlag,
  output logic       overFlowFlag,
  output logic       negativeFlag,
  output logic [3:0] shadowDepth,
  output logic       ccrError
);

  // Incoming ALU flags packed in the internal {V,Z,N,C} order.
  logic [3:0] flags_in;
  logic [3:0] flags_q, flags_d;

  assign flags_in = {overFlowFlagIn, zeroFlagIn, negativeFlagIn, carryFlagIn};

`ifdef CCR_SHADOW_EN

  logic [DEPTH-1:0][3:0] stack_q, stack_d;
  logic [3:0]            depth_q, depth_d;
  logic                  err_q, err_d;
  logic [3:0]            top;
  logic                  empty;
  logic                  full;

  assign empty = (depth_q == 4'd0);
  assign full  = (depth_q == 4'(DEPTH));

  // Select entry[depth-1]; a loop compare avoids an out-of-range index when empty.
  always_comb begin
    top = 4'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == 4'(i + 1)) top = stack_q[i];
    end
  end

  // Next-state: pop beats push; an illegal op still lets flagWrite through
  // except when push and pop collide, where the pop owns the flags.
  always_comb begin
    flags_d = flags_q;
    stack_d = stack_q;
    depth_d = depth_q;
    err_d   = 1'b0;
    if (!stall) begin
      if (pop && push) begin
        err_d = 1'b1;
        if (!empty) begin
          flags_d = top;
          depth_d = depth_q - 4'd1;
        end
      end else if (pop) begin
        if (!empty) begin
          flags_d = top;
          depth_d = depth_q - 4'd1;
        end else begin
          err_d = 1'b1;
          if (flagWrite) flags_d = flags_in;
        end
      end else if (push) begin
        if (!full) begin
          // Save the pre-edge flags; a concurrent write only affects flags_d.
          for (int i = 0; i < DEPTH; i++) begin
            if (depth_q == 4'(i)) stack_d[i] = flags_q;
          end
          depth_d = depth_q + 4'd1;
        end else begin
          err_d = 1'b1;
        end
        if (flagWrite) flags_d = flags_in;
      end else if (flagWrite) begin
        flags_d = flags_in;
      end
    end
  end

  // State registers; reset clears flags, pointer, error and every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= 4'd0;
      stack_q <= '0;
      depth_q <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      stack_q <= stack_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  assign shadowDepth = depth_q;
  assign ccrError    = err_q;

`else

  // push/pop have no effect without the shadow stack.
  logic unused_stack_ops;
  assign unused_stack_ops = push ^ pop;

  // Flag load: write-enable gated by stall.
  always_comb begin
    flags_d = flags_q;
    if (!stall && flagWrite) flags_d = flags_in;
  end

  // Flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= 4'd0;
    else     flags_q <= flags_d;
  end

  assign shadowDepth = 4'd0;
  assign ccrError    = 1'b0;

`endif

  assign overFlowFlag = flags_q[3];
  assign zeroFlag     = flags_q[2];
  assign negativeFlag = flags_q[1];
  assign carryFlag    = flags_q[0];

endmodule
